// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between the scan controller, its host, the shared seg7 decoder and the display.
// master = host/decoder side, slave = scan controller.
interface seg7_scan_ctrl_if;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dec_digit;
    logic [6:0]  dec_segments;
    logic [6:0]  segments;
    logic [3:0]  anode;
    logic        frame_start;

    modport master (
        output enable,
        output digits_in,
        output dec_segments,
        input  dec_digit,
        input  segments,
        input  anode,
        input  frame_start
    );

    modport slave (
        input  enable,
        input  digits_in,
        input  dec_segments,
        output dec_digit,
        output segments,
        output anode,
        output frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with BLANK/SHOW dead-time and one shared decoder.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN suppresses segments of leading-zero digits 3..1.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam int MAX_CNT = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       sel;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      digit_lat;

    logic             latch_cycle;
    logic             show_on;
    logic             hide_digit;

    // Frame boundary: start of the dead-time in front of digit 0.
    assign latch_cycle = bus.enable && (state == BLANK) && (sel == 2'd0) && (cnt == '0);
    assign show_on     = bus.enable && (state == SHOW);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BLANK;
            sel       <= 2'd0;
            cnt       <= '0;
            digit_lat <= 16'h0000;
        end else if (!bus.enable) begin
            state <= BLANK;
            cnt   <= '0;
        end else begin
            if (latch_cycle) begin
                digit_lat <= bus.digits_in;
            end
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        sel   <= sel + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        hide_digit = 1'b0;
        case (sel)
            2'd3:    hide_digit = (digit_lat[15:12] == 4'h0);
            2'd2:    hide_digit = (digit_lat[15:8]  == 8'h00);
            2'd1:    hide_digit = (digit_lat[15:4]  == 12'h000);
            default: hide_digit = 1'b0;
        endcase
    end
`else
    assign hide_digit = 1'b0;
`endif

    // The decoder sees the selected digit in both phases so it settles during BLANK.
    assign bus.dec_digit   = digit_lat[{sel, 2'b00} +: 4];
    assign bus.frame_start = latch_cycle && reset_n;

    always_comb begin
        bus.anode    = 4'b0000;
        bus.segments = 7'b0000000;
        if (show_on) begin
            bus.anode[sel] = 1'b1;
            if (!hide_digit) begin
                bus.segments = bus.dec_segments;
            end
        end
    end

    always_comb begin
        assert ($onehot0(bus.anode));
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_seg7_scan_ctrl;

    localparam int S      = 4;
    localparam int B      = 2;
    localparam int PERIOD = S + B;
    localparam int FRAME  = 4 * PERIOD;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .SCAN_DIV    (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_lut(input logic [3:0] c);
        case (c)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign bus.dec_segments = seg_lut(bus.dec_digit);

    // Model: position within the frame, latched word, reset flag, inputs of the current cycle.
    int          m_pos;
    logic [15:0] m_lat;
    logic        in_rst;
    logic        cur_en;
    logic [15:0] cur_dig;

    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [15:0] act_v;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [15:0] expect_now();
        int d;
        int r;
        logic [3:0] dd;
        logic [3:0] an;
        logic [6:0] sg;
        logic fs;
        if (in_rst) return 16'h0000;
        d  = m_pos / PERIOD;
        r  = m_pos % PERIOD;
        dd = m_lat[4*d +: 4];
        an = 4'b0000;
        sg = 7'h00;
        fs = 1'b0;
        if (cur_en) begin
            if (r < B) begin
                fs = (m_pos == 0);
            end else begin
                an = 4'(1 << d);
                if (!(LZB && d > 0 && (m_lat >> (4*d)) == 16'h0000)) sg = seg_lut(dd);
            end
        end
        return {fs, an, sg, dd};
    endfunction

    task automatic advance();
        if (cur_en) begin
            if (m_pos == 0) m_lat = cur_dig;
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_pos = (m_pos / PERIOD) * PERIOD;
        end
    endtask

    task automatic check_reset_state();
        vectors++;
        if ((bus.anode !== 4'b0000) || (bus.segments !== 7'h00) ||
            (bus.frame_start !== 1'b0) || (bus.dec_digit !== 4'h0)) begin
            miscompares++;
            $display("FAIL reset state t=%0t fs=%b an=%b seg=%h dig=%h",
                     $time, bus.frame_start, bus.anode, bus.segments, bus.dec_digit);
        end
    endtask

    task automatic cycle(input logic en, input logic [15:0] dig);
        @(posedge clk);
        if (!in_rst) advance();
        #1;
        bus.enable    = en;
        bus.digits_in = dig;
        cur_en        = en;
        cur_dig       = dig;
        exp_q.push_back(expect_now());
    endtask

    task automatic release_reset(input logic en, input logic [15:0] dig);
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        in_rst        = 1'b0;
        m_pos         = 0;
        m_lat         = 16'h0000;
        bus.enable    = en;
        bus.digits_in = dig;
        cur_en        = en;
        cur_dig       = dig;
        exp_q.push_back(expect_now());
    endtask

    task automatic async_reset();
        @(posedge clk);
        if (!in_rst) advance();
        #3;
        reset_n = 1'b0;
        in_rst  = 1'b1;
        m_pos   = 0;
        m_lat   = 16'h0000;
        exp_q.push_back(expect_now());
        #1;
        check_reset_state();
    endtask

    task automatic run_to(input int d, input logic [15:0] dig);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (cur_en && !in_rst && (m_pos / PERIOD == d) && (m_pos % PERIOD >= B)) begin
                reached = 1'b1;
                break;
            end
            cycle(1'b1, dig);
        end
        if (!reached && !(cur_en && !in_rst && (m_pos / PERIOD == d) && (m_pos % PERIOD >= B))) begin
            miscompares++;
            $display("FAIL wait expired t=%0t: SHOW of digit %0d not reached", $time, d);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.frame_start, bus.anode, bus.segments, bus.dec_digit};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs t=%0t got fs=%b an=%b seg=%h dig=%h expected fs=%b an=%b seg=%h dig=%h",
                         $time, act_v[15], act_v[14:11], act_v[10:4], act_v[3:0],
                         exp_v[15], exp_v[14:11], exp_v[10:4], exp_v[3:0]);
            end
        end
    end

    initial begin
        logic [15:0] pats[4];
        logic [15:0] rdig;
        logic        ren;
        pats[0] = 16'h00A0;
        pats[1] = 16'h0050;
        pats[2] = 16'h0000;
        pats[3] = 16'hF00E;

        in_rst        = 1'b1;
        m_pos         = 0;
        m_lat         = 16'h0000;
        cur_en        = 1'b1;
        cur_dig       = 16'h4321;
        bus.enable    = 1'b1;
        bus.digits_in = 16'h4321;

        #1;
        check_reset_state();

        repeat (2) cycle(1'b1, 16'h4321);
        release_reset(1'b1, 16'h4321);
        repeat (30) cycle(1'b1, 16'h4321);

        // Mid-frame input change must wait for the next latch cycle.
        run_to(1, 16'h4321);
        repeat (2 * FRAME + 4) cycle(1'b1, 16'h8765);

        // Freeze during digit 2, then resume with full dead-time.
        run_to(2, 16'h8765);
        repeat (10) cycle(1'b0, 16'h8765);
        repeat (12) cycle(1'b1, 16'h8765);

        foreach (pats[i]) begin
            repeat (FRAME + 2) cycle(1'b1, pats[i]);
        end

        // Asynchronous reset in the middle of a SHOW phase.
        run_to(3, 16'hF00E);
        async_reset();
        repeat (2) cycle(1'b1, 16'h1234);
        release_reset(1'b1, 16'h1234);
        repeat (FRAME + 4) cycle(1'b1, 16'h1234);

        rdig = 16'h1234;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) begin
                rdig = 16'($urandom);
                if ($urandom_range(1) == 0) rdig = rdig & (16'hFFFF >> (4 * $urandom_range(3)));
            end
            ren = ($urandom_range(15) != 0);
            cycle(ren, rdig);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
